// File: rtl/path_encoder_if.sv
// Position-in / opcode-out bundle between the position tracker and path_encoder.
// Latency: none, wires only.
// Backpressure: pos_ready throttles positions, op_ready throttles opcodes.
interface path_encoder_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [3:0]       start_x;
    logic [3:0]       start_y;
    logic             pos_valid;
    logic [3:0]       pos_x;
    logic [3:0]       pos_y;
    logic             pos_ready;
    logic             op_valid;
    logic [1:0]       op;
    logic             op_ready;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] move_count;

    // Producer/consumer side: drives positions and starts, takes opcodes.
    modport master (
        output start, start_x, start_y, pos_valid, pos_x, pos_y, op_ready,
        input  pos_ready, op_valid, op, busy, err, move_count
    );

    // Encoder side.
    modport slave (
        input  start, start_x, start_y, pos_valid, pos_x, pos_y, op_ready,
        output pos_ready, op_valid, op, busy, err, move_count
    );
endinterface

// File: rtl/path_encoder.sv
// Small synchronous FIFO with flush; head data is 0 when empty.
// Latency: 1 cycle from push to head visible.
// Backpressure: push ignored when full, pop ignored when empty.
module path_encoder_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_push_dat,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_head_dat,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = o_empty ? '0 : r_mem[r_rptr];

    // Storage array: written on push, never reset (occupancy tracks validity).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Pointers and occupancy; flush empties the queue like a reset.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// Converts a stream of grid positions into 2-bit move opcodes, flags non-unit steps.
// Latency: accepted position -> opcode at FIFO head 1 cycle later when FIFO empty.
// Backpressure: pos_ready low while FIFO full (no same-cycle pop bypass), in start cycle, or outside TRACK.
module path_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    path_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cx;
    logic [3:0]         r_cy;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [3:0]         w_dx;
    logic [3:0]         w_dy;
    logic               w_same;
    logic               w_legal;
    logic [1:0]         w_op;
    logic               w_pos_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_bad;
    logic               w_full;
    logic               w_empty;
    logic [1:0]         w_head;
    logic [$clog2(DEPTH):0] w_fifo_count;

    // Differences are mod 16, so wrap steps (15->0, 0->15) classify as unit moves.
    assign w_dx = bus.pos_x - r_cx;
    assign w_dy = bus.pos_y - r_cy;

    // Classify the offered position against the current one.
    always_comb begin
        w_op    = 2'b00;
        w_legal = 1'b0;
        w_same  = (w_dx == 4'h0) && (w_dy == 4'h0);
        if (w_dx == 4'h0 && w_dy == 4'hF) begin
            w_op    = 2'b00;
            w_legal = 1'b1;
        end else if (w_dx == 4'h0 && w_dy == 4'h1) begin
            w_op    = 2'b11;
            w_legal = 1'b1;
        end else if (w_dx == 4'hF && w_dy == 4'h0) begin
            w_op    = 2'b10;
            w_legal = 1'b1;
        end else if (w_dx == 4'h1 && w_dy == 4'h0) begin
            w_op    = 2'b01;
            w_legal = 1'b1;
        end
    end

    assign w_pos_ready = (r_state == S_TRACK) && !bus.start && !w_full;
    assign w_accept    = bus.pos_valid && w_pos_ready;
    assign w_push      = w_accept && w_legal;
    assign w_bad       = w_accept && !w_legal && !w_same;

    path_encoder_fifo #(
        .W     (2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.start),
        .i_push     (w_push),
        .i_push_dat (w_op),
        .i_pop      (bus.op_ready),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign bus.pos_ready  = w_pos_ready;
    assign bus.op_valid   = !w_empty;
    assign bus.op         = w_head;
    assign bus.busy       = (r_state == S_TRACK);
    assign bus.err        = r_err;
    assign bus.move_count = r_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start restarts from any state; a bad step parks in ERROR.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = S_TRACK;
        end else if (w_bad) begin
            w_state_nxt = S_ERROR;
        end
    end

    // Current position, sticky error and saturating move counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cx  <= 4'h0;
            r_cy  <= 4'h0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (bus.start) begin
            r_cx  <= bus.start_x;
            r_cy  <= bus.start_y;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_cx <= bus.pos_x;
                r_cy <= bus.pos_y;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^w_fifo_count;
endmodule

// File: tb/tb_path_encoder.sv
// Directed bench for path_encoder with an opcode scoreboard.
// Latency: checks opcode order as popped, one cycle after acceptance.
// Backpressure: exercises full-FIFO stall and ERROR blocking.
module tb_path_encoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    path_encoder_if #(.CNT_W(8)) ifc ();

    path_encoder #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int         tests = 0;
    int         fails = 0;
    logic [1:0] sb_q[$];
    bit         last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        logic [1:0] exp_op;
        #1;
        last_acc = ifc.pos_valid && ifc.pos_ready;
        if (!rst && !ifc.start && ifc.op_valid && ifc.op_ready) begin
            check("op_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_op = sb_q.pop_front();
                check("op_order", 32'(ifc.op), 32'(exp_op));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pos(input logic [3:0] x, input logic [3:0] y,
                            input bit exp_push, input logic [1:0] exp_op);
        bit done;
        done = 1'b0;
        ifc.pos_valid = 1'b1;
        ifc.pos_x     = x;
        ifc.pos_y     = y;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (last_acc) begin
                done = 1'b1;
                if (exp_push) sb_q.push_back(exp_op);
            end
        end
        check("pos_accept", 32'(done), 32'd1);
        ifc.pos_valid = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] x, input logic [3:0] y);
        ifc.start   = 1'b1;
        ifc.start_x = x;
        ifc.start_y = y;
        sb_q.delete();
        tick();
        ifc.start   = 1'b0;
    endtask

    task automatic drain(input int n);
        ifc.op_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst           = 1'b1;
        ifc.start     = 1'b0;
        ifc.start_x   = 4'h0;
        ifc.start_y   = 4'h0;
        ifc.pos_valid = 1'b0;
        ifc.pos_x     = 4'h0;
        ifc.pos_y     = 4'h0;
        ifc.op_ready  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_pos_ready", 32'(ifc.pos_ready), 32'd0);
        check("rst_op_valid", 32'(ifc.op_valid), 32'd0);
        check("rst_op", 32'(ifc.op), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_err", 32'(ifc.err), 32'd0);
        check("rst_count", 32'(ifc.move_count), 32'd0);
        @(negedge clk);

        // Basic square walk.
        do_start(4'd5, 4'd5);
        check("t1_busy", 32'(ifc.busy), 32'd1);
        ifc.op_ready = 1'b1;
        send_pos(4'd5, 4'd4, 1'b1, 2'b00);
        send_pos(4'd4, 4'd4, 1'b1, 2'b10);
        send_pos(4'd4, 4'd5, 1'b1, 2'b11);
        send_pos(4'd5, 4'd5, 1'b1, 2'b01);
        drain(4);
        check("t1_count", 32'(ifc.move_count), 32'd4);
        check("t1_err", 32'(ifc.err), 32'd0);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // Wrap-around steps.
        do_start(4'd0, 4'd0);
        send_pos(4'd0, 4'd15, 1'b1, 2'b00);
        send_pos(4'd15, 4'd15, 1'b1, 2'b10);
        drain(4);
        check("t2_count", 32'(ifc.move_count), 32'd2);
        check("t2_err", 32'(ifc.err), 32'd0);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Full FIFO stall, no bypass, order preserved.
        do_start(4'd3, 4'd3);
        ifc.op_ready = 1'b0;
        send_pos(4'd3, 4'd2, 1'b1, 2'b00);
        send_pos(4'd2, 4'd2, 1'b1, 2'b10);
        send_pos(4'd2, 4'd3, 1'b1, 2'b11);
        send_pos(4'd3, 4'd3, 1'b1, 2'b01);
        ifc.pos_valid = 1'b1;
        ifc.pos_x     = 4'd4;
        ifc.pos_y     = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_full_hold", 32'(last_acc), 32'd0);
        end
        check("t3_op_valid", 32'(ifc.op_valid), 32'd1);
        ifc.op_ready = 1'b1;
        tick();
        check("t3_no_bypass", 32'(last_acc), 32'd0);
        ifc.op_ready = 1'b0;
        tick();
        check("t3_accept_after_pop", 32'(last_acc), 32'd1);
        if (last_acc) sb_q.push_back(2'b01);
        ifc.pos_valid = 1'b0;
        check("t3_count", 32'(ifc.move_count), 32'd5);
        drain(8);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Same-position sample consumed without opcode.
        do_start(4'd7, 4'd7);
        send_pos(4'd7, 4'd7, 1'b0, 2'b00);
        check("t4_same_count", 32'(ifc.move_count), 32'd0);
        send_pos(4'd8, 4'd7, 1'b1, 2'b01);
        drain(3);
        check("t4_count", 32'(ifc.move_count), 32'd1);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Illegal step into ERROR, drain, restart.
        do_start(4'd2, 4'd2);
        ifc.op_ready = 1'b0;
        send_pos(4'd2, 4'd3, 1'b1, 2'b11);
        send_pos(4'd4, 4'd4, 1'b0, 2'b00);
        ifc.pos_valid = 1'b1;
        ifc.pos_x     = 4'd2;
        ifc.pos_y     = 4'd4;
        #1;
        check("t5_err", 32'(ifc.err), 32'd1);
        check("t5_busy", 32'(ifc.busy), 32'd0);
        check("t5_pos_ready", 32'(ifc.pos_ready), 32'd0);
        check("t5_op_valid", 32'(ifc.op_valid), 32'd1);
        check("t5_op", 32'(ifc.op), 32'd3);
        check("t5_count", 32'(ifc.move_count), 32'd1);
        @(negedge clk);
        ifc.pos_valid = 1'b0;
        drain(3);
        check("t5_drained", 32'(ifc.op_valid), 32'd0);
        check("t5_err_sticky", 32'(ifc.err), 32'd1);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
        do_start(4'd9, 4'd9);
        check("t5_restart_err", 32'(ifc.err), 32'd0);
        check("t5_restart_op_valid", 32'(ifc.op_valid), 32'd0);
        check("t5_restart_count", 32'(ifc.move_count), 32'd0);
        check("t5_restart_busy", 32'(ifc.busy), 32'd1);

        // Start flushes queued opcodes even with a pop offered.
        ifc.op_ready = 1'b0;
        send_pos(4'd10, 4'd9, 1'b1, 2'b01);
        ifc.op_ready = 1'b1;
        do_start(4'd1, 4'd1);
        check("t5b_flush", 32'(ifc.op_valid), 32'd0);

        // Reset mid-path with two opcodes queued.
        ifc.op_ready = 1'b0;
        send_pos(4'd1, 4'd0, 1'b1, 2'b00);
        send_pos(4'd2, 4'd0, 1'b1, 2'b01);
        check("t6_queued", 32'(ifc.op_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("t6_op_valid", 32'(ifc.op_valid), 32'd0);
        check("t6_count", 32'(ifc.move_count), 32'd0);
        check("t6_busy", 32'(ifc.busy), 32'd0);
        check("t6_pos_ready", 32'(ifc.pos_ready), 32'd0);
        @(negedge clk);
        do_start(4'd6, 4'd6);
        ifc.op_ready = 1'b1;
        send_pos(4'd6, 4'd7, 1'b1, 2'b11);
        drain(3);
        check("t6_resume_count", 32'(ifc.move_count), 32'd1);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        // Move counter saturates at all-ones.
        do_start(4'd0, 4'd0);
        for (int i = 1; i <= 260; i++) begin
            send_pos(4'd0, 4'(i), 1'b1, 2'b11);
        end
        drain(3);
        check("sat_count", 32'(ifc.move_count), 32'd255);
        check("sat_err", 32'(ifc.err), 32'd0);
        check("sat_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/path_encoder.md
Name: path_encoder

Overview:
- Inverse of the move translation step. Consumes a stream of successive 4-bit (x,y) grid positions and emits the 2-bit move opcode that takes each position to the next.
- Buffers the emitted opcodes in a small FIFO. Flags any step that is not a single-cell move.
- Sits between the maze-walk/position tracker and the move-replay or logging logic.

Parameters:
- DEPTH, 4, opcode FIFO depth in entries (power of two, at least 2).
- CNT_W, 8, width of the move counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; loads the start position and begins a new path
- start_x  input  4  start x coordinate, sampled when start=1
- start_y  input  4  start y coordinate, sampled when start=1
- pos_valid  input  1  next-position sample valid
- pos_x  input  4  next-position x
- pos_y  input  4  next-position y
- pos_ready  output  1  block accepts a position this cycle
- op_valid  output  1  FIFO head opcode valid
- op  output  2  FIFO head opcode
- op_ready  input  1  consumer takes the head opcode
- busy  output  1  state is TRACK
- err  output  1  sticky illegal-step flag
- move_count  output  CNT_W  number of opcodes pushed since start, saturating

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything):
  - state=IDLE; current position (cx,cy)=(0,0); FIFO empty.
  - Outputs: pos_ready=0, op_valid=0, op=00, busy=0, err=0, move_count=0.
- Opcode encoding, all arithmetic mod 16 on 4 bits:
  - 00 up: nx=cx, ny=cy-1
  - 11 down: nx=cx, ny=cy+1
  - 10 left: nx=cx-1, ny=cy
  - 01 right: nx=cx+1, ny=cy
  - Wrap steps are legal: (x,0)->(x,15) is up; (15,y)->(0,y) is right.
- States are IDLE, TRACK and ERROR.
- start=1 in any state, next cycle:
  - (cx,cy) loads (start_x,start_y); FIFO is flushed; err=0; move_count=0; state=TRACK.
  - No position is accepted in the start cycle, because pos_ready is forced to 0.
  - An op pop in the start cycle is discarded.
- pos_ready = (state==TRACK) && !start && (fifo_count<DEPTH).
  - No same-cycle pop bypass when the FIFO is full.
- Accept happens when pos_valid && pos_ready. It is classified combinationally against (cx,cy):
  - Same position: consumed, no push, no count change, (cx,cy) unchanged.
  - Adjacent per the table: push the opcode, (cx,cy) takes the sample, move_count+1 (saturates at all-ones).
  - Anything else, including diagonal: no push, (cx,cy) unchanged, err=1 next cycle, state=ERROR.
- ERROR:
  - pos_ready=0; err held; busy=0.
  - The FIFO keeps draining normally.
  - Exit only by start or rst.
- IDLE: pos_ready=0. The FIFO is empty after reset, or drains if entered by a future extension.
- FIFO:
  - op_valid = fifo_count!=0. op = head entry, or 00 when empty.
  - A pop happens on op_valid && op_ready.
  - A simultaneous push and pop in one cycle is legal; fifo_count stays the same.
  - Pointers wrap modulo DEPTH.
  - Latency from an accepting pos edge to op_valid is 1 cycle when the FIFO was empty.
- pos_x/pos_y are don't-care when pos_valid=0. op_ready is ignored when op_valid=0.

Test Plan:
- Reset then start with (5,5), feed positions (5,4),(4,4),(4,5),(5,5) with op_ready=1 -> ops 00,10,11,01 in order, move_count=4, err=0.
- Start at (0,0), feed (0,15) then (15,15) -> ops 00 then 10, showing wrap-around legality.
- Start at (3,3), op_ready=0, feed 5 distinct legal steps with DEPTH=4 -> pos_ready drops after the 4th accept and the 5th is held. Raise op_ready for one cycle -> one pop, then the 5th is accepted next cycle, and the order is preserved.
- Start at (7,7), feed (7,7) then (8,7) -> single op 01, move_count=1.
- Start at (2,2), push op 11 via (2,3), then feed (4,4) -> err=1, state ERROR, pos_ready=0, pending 11 still drains. Pulse start with (9,9) -> err=0, FIFO empty, move_count=0, busy=1.
- Mid-path with 2 ops queued, assert rst for one cycle -> next cycle op_valid=0, move_count=0, busy=0, pos_ready=0; a later start resumes normally.
